mem_stream_reader: RTL and testbench

Sequential read-port engine for the 1-write/1-read register/LVT memories: on a start command it walks a contiguous address range on the memory's read port and delivers each word on a valid/ready stream. It absorbs the memory's one-cycle registered read latency with a 2-entry skid FIFO, so the stream sustains one word per cycle under no backpressure. It sits between a memory read port and any consumer that needs bulk readout, such as debug dump, context save or register-file scan.

---
 rtl/mem_stream_reader.sv | 177 +++++++++++++++++
 tb/tb_mem_stream_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Sequential read-port walker: streams a contiguous address range
// through a 2-entry skid FIFO that hides the memory read latency.
module mem_stream_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   start_count,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH+1)'(1);

  state_t state_q;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  busy_q;
  logic                  done_q;

  logic [1:0][DATA_WIDTH-1:0] fifo_data_q;
  logic [1:0]                 fifo_last_q;
  logic                       rd_ptr_q;
  logic                       wr_ptr_q;
  logic [1:0]                 fifo_count_q;

  logic       accept;
  logic       cmd_empty;
  logic       push;
  logic       pop;
  logic [2:0] occ;
  logic       credit;
  logic       issue;
  logic       issue_last;
  logic       last_hs;

  assign out_valid = (fifo_count_q != 2'd0);
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q]
                               : '0;
  assign out_last  = out_valid & fifo_last_q[rd_ptr_q];

  assign start_ready   = (state_q == IDLE);
  assign mem_read_addr = addr_q;
  assign busy          = busy_q;
  assign done          = done_q;

  assign accept    = start_ready & start_valid;
  assign cmd_empty = (start_count == '0);
  assign push      = inflight_q;
  assign pop       = out_valid & out_ready;
  assign last_hs   = pop & out_last;

  // Words held or on their way, after this cycle's pop.
  assign occ = {1'b0, fifo_count_q}
             + {2'b00, inflight_q}
             - {2'b00, pop};
  assign credit = (occ < 3'd2);

  assign issue = (state_q == RUN)
               & (remaining_q != '0)
               & credit;
  assign issue_last = issue & (remaining_q == ONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !cmd_empty) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (issue_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= start_addr;
        remaining_q <= start_count;
      end else if (issue) begin
        addr_q      <= addr_q + 1'b1;
        remaining_q <= remaining_q - ONE;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_data_q  <= '0;
      fifo_last_q  <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_read_data;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_count_q <= fifo_count_q
                    + {1'b0, push}
                    - {1'b0, pop};
    end
  end

  // An empty command completes on its acceptance edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        busy_q <= !cmd_empty;
      end else if (last_hs) begin
        busy_q <= 1'b0;
      end
      done_q <= (accept & cmd_empty)
              | ((state_q == DRAIN) & last_hs);
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(push && !pop && fifo_count_q == 2'd2)
  );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: table of commands, scoreboard queue
// of expected words, registered-read memory model.
module tb_mem_stream_reader;

  logic        clock;
  logic        reset_n;
  logic        start_valid;
  logic        start_ready;
  logic [4:0]  start_addr;
  logic [5:0]  start_count;
  logic [4:0]  mem_read_addr;
  logic [31:0] mem_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  int tests;
  int failed;

  logic [31:0] mem [32];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [4:0]  addr;
    logic [5:0]  count;
    int          mode;
    int          coh;
    int          rst_after;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs [8];

  mem_stream_reader #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .start_addr   (start_addr),
    .start_count  (start_count),
    .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    mem_read_data <= mem[mem_read_addr];
  end

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, want);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int issues;
    int pops;
    int max_out;
    int first_valid;
    int last_hs_n;
    int done_n;
    int done_cnt;
    int bad_last;
    int bad_empty;
    int coh_done;
    int finished;
    logic [4:0]  prev;
    logic [4:0]  a;
    logic [31:0] w;
    logic [31:0] got_first;
    logic [31:0] got_last;
    issues = 0; pops = 0; max_out = 0;
    first_valid = 0; last_hs_n = 0;
    done_n = 0; done_cnt = 0;
    bad_last = 0; bad_empty = 0;
    coh_done = 0; finished = 0;
    prev = '0; got_first = '0; got_last = '0;
    for (int i = 0; i < 20 && !start_ready; i++) begin
      @(negedge clock);
    end
    check("start_ready_wait", start_ready, 1);
    exp_q.delete();
    for (int i = 0; i < int'(v.count); i++) begin
      a = v.addr + 5'(i);
      w = (v.coh != 0 && a == 5'd5) ? 32'hDEAD : mem[a];
      exp_q.push_back(w);
    end
    start_valid = 1'b1;
    start_addr  = v.addr;
    start_count = v.count;
    out_ready   = 1'b0;
    for (n = 1; n <= 300 && finished == 0; n++) begin
      @(negedge clock);
      start_valid = 1'b0;
      out_ready = (v.mode == 0) ? 1'b1 : (n % 3 == 0);
      #1;
      if (n == 1) begin
        prev = mem_read_addr;
        check("busy_after_accept", busy,
              (v.count != 0));
      end else if (mem_read_addr != prev) begin
        issues++;
        prev = mem_read_addr;
      end
      if (issues - pops > max_out) max_out = issues - pops;
      if (v.rst_after != 0 && pops == v.rst_after) begin
        reset_n = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_start_ready", start_ready, 1);
        check("rst_addr", mem_read_addr, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          #1;
          check("rst_no_done", done, 0);
          check("rst_no_valid", out_valid, 0);
        end
        exp_q.delete();
        return;
      end
      if (v.coh != 0 && coh_done == 0 &&
          mem_read_addr == 5'd5) begin
        mem[5] = 32'hDEAD;
        coh_done = 1;
      end
      if (out_valid && first_valid == 0) first_valid = n;
      if (!out_valid && out_last) bad_last++;
      if (v.count == 0 && (out_valid || busy)) bad_empty++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", out_data, 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          check("word", out_data, w);
          check("last_flag", out_last, (exp_q.size() == 0));
          if (pops == 0) got_first = out_data;
          pops++;
          if (exp_q.size() == 0) begin
            last_hs_n = n;
            got_last = out_data;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_n = n;
        check("done_start_ready", start_ready, 1);
        check("done_busy", busy, 0);
      end
      if (done_cnt > 0 && n > done_n + 2) finished = 1;
    end
    check("finished_in_budget", finished, 1);
    check("words_left", exp_q.size(), 0);
    check("done_count", done_cnt, 1);
    check("issue_count", issues, int'(v.count));
    check("credit_bound", (max_out <= 2), 1);
    check("last_only_valid", bad_last, 0);
    if (v.count == 0) begin
      check("empty_quiet", bad_empty, 0);
      check("empty_done_cycle", done_n, 1);
    end else begin
      check("first_valid_cycle", first_valid, 3);
      check("done_cycle", done_n, last_hs_n + 1);
      check("first_word", got_first, v.exp_first);
      check("last_word", got_last, v.exp_last);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    reset_n = 1'b0;
    start_valid = 1'b0;
    start_addr = '0;
    start_count = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'hA000 + 32'(i);
    end

    vecs[0] = '{5'd3,  6'd4,  0, 0, 0,
                32'hA003, 32'hA006};
    vecs[1] = '{5'd3,  6'd4,  1, 0, 0,
                32'hA003, 32'hA006};
    vecs[2] = '{5'd31, 6'd32, 0, 0, 0,
                32'hA01F, 32'hA01E};
    vecs[3] = '{5'd0,  6'd0,  0, 0, 0,
                32'h0, 32'h0};
    vecs[4] = '{5'd3,  6'd6,  0, 1, 0,
                32'hA003, 32'hA008};
    vecs[5] = '{5'd8,  6'd8,  0, 0, 2,
                32'hA008, 32'hA00F};
    vecs[6] = '{5'd12, 6'd3,  1, 0, 0,
                32'hA00C, 32'hA00E};
    vecs[7] = '{5'd28, 6'd6,  0, 0, 0,
                32'hA01C, 32'hA001};

    repeat (2) @(negedge clock);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_data", out_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_start_ready", start_ready, 1);
    check("reset_addr", mem_read_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int t = 0; t < 8; t++) begin
      run_vec(vecs[t]);
    end

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
